// File: rtl/ifu_fetch_buf_if.sv
// Core-side and ROM-side handshake bundle for the instruction fetch buffer.
// slave = fetch buffer view; master = core/ROM environment view.
interface ifu_fetch_buf_if;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_o;
    logic [3:0]  rom_sel_o;
    logic        rom_we_o;
    logic        rom_req_valid_o;
    logic        rom_req_ready_i;
    logic [31:0] rom_data_i;
    logic        rom_rsp_valid_i;
    logic        rom_rsp_ready_o;

    modport slave (
        input  flush_i, flush_addr_i, inst_ready_i, rom_req_ready_i, rom_data_i, rom_rsp_valid_i,
        output inst_valid_o, inst_o, inst_addr_o, rom_addr_o, rom_data_o, rom_sel_o, rom_we_o,
               rom_req_valid_o, rom_rsp_ready_o
    );

    modport master (
        output flush_i, flush_addr_i, inst_ready_i, rom_req_ready_i, rom_data_i, rom_rsp_valid_i,
        input  inst_valid_o, inst_o, inst_addr_o, rom_addr_o, rom_data_o, rom_sel_o, rom_we_o,
               rom_req_valid_o, rom_rsp_ready_o
    );
endinterface

// File: rtl/ifu_fetch_buf.sv
// Sequential instruction fetch with in-order response FIFO and redirect drop logic.
// Define IFU_FETCH_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module ifu_fetch_buf #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    ifu_fetch_buf_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] os, drop, cnt;
    fetch_entry_t  fifo_q [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   pcq [DEPTH];
    logic [AW-1:0] pq_rd, pq_wr;

    logic req_fire, rsp_take, rsp_keep, byp, push, pop;

    // Slots are reserved at issue time, so responses can always be accepted.
    assign bus.rom_req_valid_o = !rst && !bus.flush_i &&
                                 (({1'b0, cnt} + {1'b0, os}) < (CW+1)'(DEPTH));
    assign bus.rom_addr_o      = fetch_pc;
    assign bus.rom_data_o      = 32'h0;
    assign bus.rom_sel_o       = 4'hF;
    assign bus.rom_we_o        = 1'b0;
    assign bus.rom_rsp_ready_o = 1'b1;

    assign req_fire = bus.rom_req_valid_o && bus.rom_req_ready_i;
    // A response with nothing outstanding is a leftover from before reset.
    assign rsp_take = bus.rom_rsp_valid_i && (os != '0);
    assign rsp_keep = rsp_take && (drop == '0) && !bus.flush_i;

`ifdef IFU_FETCH_BYPASS_EN
    assign byp = rsp_keep && (cnt == '0);
`else
    assign byp = 1'b0;
`endif

    assign push = rsp_keep && !(byp && bus.inst_ready_i);
    assign pop  = (cnt != '0) && bus.inst_ready_i && !bus.flush_i;

    assign bus.inst_valid_o = (cnt != '0) || byp;
    assign bus.inst_o       = byp ? bus.rom_data_i : fifo_q[rd_ptr].inst;
    assign bus.inst_addr_o  = byp ? pcq[pq_rd]     : fifo_q[rd_ptr].pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            os       <= '0;
            drop     <= '0;
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pq_rd    <= '0;
            pq_wr    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
                pcq[i]    <= '0;
            end
        end else begin
            if (req_fire) begin
                pcq[pq_wr] <= fetch_pc;
                pq_wr      <= pq_wr + AW'(1);
            end
            if (rsp_take)
                pq_rd <= pq_rd + AW'(1);
            os <= os + CW'(req_fire) - CW'(rsp_take);

            if (bus.flush_i) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= {bus.flush_addr_i[31:2], 2'b00};
                drop     <= os - CW'(rsp_take);
                cnt      <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp_take && (drop != '0))
                    drop <= drop - CW'(1);
                if (push) begin
                    fifo_q[wr_ptr] <= '{pc: pcq[pq_rd], inst: bus.rom_data_i};
                    wr_ptr         <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                cnt <= cnt + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
